// File: rtl/core_mailbox.sv
// core_mailbox: inter-core mailbox with one word FIFO per direction plus a
// status register, mapped at BASE (DATA) and BASE+1 (STATUS) on each core's data bus.
module core_mailbox #(
  parameter int TAM = 16,
  parameter int LDepth = 3,
  parameter logic [TAM-1:0] BASE = 16'h0200
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [TAM-1:0] dataIN0,
  input  logic [TAM-1:0] dataIN1,
  input  logic [TAM-1:0] dataADDR0,
  input  logic [TAM-1:0] dataADDR1,
  input  logic           dataLoad0,
  input  logic           dataLoad1,
  input  logic           dataWrite0,
  input  logic           dataWrite1,
  output logic [TAM-1:0] dataOUT0,
  output logic [TAM-1:0] dataOUT1
);
  localparam int DEPTH = 1 << LDepth;
  localparam logic [TAM-1:0] STAT = BASE + TAM'(1);
  logic [TAM-1:0] w_din [2];
  logic [TAM-1:0] w_addr [2];
  logic [TAM-1:0] w_head [2];
  logic [TAM-1:0] w_out [2];
  logic [LDepth:0] w_cnt [2];
  logic w_ld [2];
  logic w_wr [2];
  logic w_rdat [2];
  assign w_din[0] = dataIN0;
  assign w_din[1] = dataIN1;
  assign w_addr[0] = dataADDR0;
  assign w_addr[1] = dataADDR1;
  assign w_ld[0] = dataLoad0;
  assign w_ld[1] = dataLoad1;
  assign w_wr[0] = dataWrite0;
  assign w_wr[1] = dataWrite1;
  assign dataOUT0 = w_out[0];
  assign dataOUT1 = w_out[1];
  // Block k owns the FIFO written by core k and read by core P.
  for (genvar k = 0; k < 2; k++) begin : g
    localparam int P = 1 - k;
    logic [TAM-1:0] r_mem [DEPTH];
    logic [LDepth-1:0] r_wp, r_rp;
    logic [LDepth:0] r_cnt;
    logic r_unf, r_ovf;
    logic [TAM-1:0] r_out;
    logic w_hit, w_dat, w_we, w_re, w_full, w_rxne, w_push, w_pop;
    logic [TAM-1:0] w_stat;
    assign w_hit = w_addr[k] == BASE || w_addr[k] == STAT;
    assign w_dat = w_addr[k] == BASE;
    assign w_we = w_wr[k] & w_hit;
    assign w_re = w_ld[k] & w_hit & ~w_wr[k];
    assign w_full = r_cnt == (LDepth+1)'(DEPTH);
    assign w_rxne = w_cnt[P] != '0;
    assign w_push = w_we & w_dat & ~w_full;
    assign w_pop = w_rdat[P] & (r_cnt != '0);
    assign w_stat = (TAM'(w_cnt[P]) << 8) | TAM'({r_ovf, r_unf, w_full, w_rxne});
    assign w_rdat[k] = w_re & w_dat;
    assign w_cnt[k] = r_cnt;
    assign w_head[k] = r_mem[r_rp];
    assign w_out[k] = r_out;
    always_ff @(posedge clk)
      if (rst && w_push) r_mem[r_wp] <= w_din[k];
    always_ff @(posedge clk) begin
      if (!rst) begin
        r_wp <= '0;
        r_rp <= '0;
        r_cnt <= '0;
        r_unf <= 1'b0;
        r_ovf <= 1'b0;
        r_out <= '0;
      end else begin
        if (w_push) r_wp <= r_wp + 1'b1;
        if (w_pop) r_rp <= r_rp + 1'b1;
        r_cnt <= r_cnt + (LDepth+1)'(w_push) - (LDepth+1)'(w_pop);
        if (w_we && w_dat && w_full) r_ovf <= 1'b1;
        else if (w_we && !w_dat && w_din[k][3]) r_ovf <= 1'b0;
        if (w_re && w_dat && !w_rxne) r_unf <= 1'b1;
        else if (w_we && !w_dat && w_din[k][2]) r_unf <= 1'b0;
        if (w_re) r_out <= !w_dat ? w_stat : w_rxne ? w_head[P] : '0;
      end
    end
  end
endmodule

// File: tb/tb_core_mailbox.sv
// tb_core_mailbox: vector table, directed corner sequences and a random run
// against a queue-based reference model of both mailbox directions.
module tb_core_mailbox;
  localparam logic [15:0] B = 16'h0200, S = 16'h0201, M = 16'h0202;
  logic clk = 1'b0, rst = 1'b0;
  logic [15:0] dataIN0 = '0, dataIN1 = '0, dataADDR0 = '0, dataADDR1 = '0;
  logic dataLoad0 = 1'b0, dataLoad1 = 1'b0, dataWrite0 = 1'b0, dataWrite1 = 1'b0;
  logic [15:0] dataOUT0, dataOUT1;
  int total = 0, bad = 0;
  logic [15:0] q [2][$];
  bit unf [2], ovf [2];
  logic [15:0] mo [2];

  typedef struct {
    logic [15:0] a0, d0; logic l0, w0;
    logic [15:0] a1, d1; logic l1, w1;
    logic [15:0] e0, e1;
  } vec_t;
  vec_t tv [14];

  core_mailbox #(.TAM(16), .LDepth(3), .BASE(16'h0200)) dut (
    .clk(clk), .rst(rst),
    .dataIN0(dataIN0), .dataIN1(dataIN1),
    .dataADDR0(dataADDR0), .dataADDR1(dataADDR1),
    .dataLoad0(dataLoad0), .dataLoad1(dataLoad1),
    .dataWrite0(dataWrite0), .dataWrite1(dataWrite1),
    .dataOUT0(dataOUT0), .dataOUT1(dataOUT1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [15:0] a, input logic [15:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask

  task automatic step(input logic r,
                      input logic [15:0] a0, input logic [15:0] d0, input logic l0, input logic w0,
                      input logic [15:0] a1, input logic [15:0] d1, input logic l1, input logic w1);
    logic [15:0] a [2], d [2];
    logic l [2], w [2];
    int n [2];
    bit pu [2], po [2];
    a = '{a0, a1}; d = '{d0, d1}; l = '{l0, l1}; w = '{w0, w1};
    rst = r;
    dataADDR0 = a0; dataIN0 = d0; dataLoad0 = l0; dataWrite0 = w0;
    dataADDR1 = a1; dataIN1 = d1; dataLoad1 = l1; dataWrite1 = w1;
    @(posedge clk);
    #1;
    if (!r) begin
      q[0].delete(); q[1].delete();
      unf = '{0, 0}; ovf = '{0, 0}; mo = '{16'h0, 16'h0};
    end else begin
      n[0] = q[0].size(); n[1] = q[1].size();
      pu = '{0, 0}; po = '{0, 0};
      for (int k = 0; k < 2; k++) begin
        int p;
        p = 1 - k;
        if ((a[k] == B || a[k] == S) && w[k]) begin
          if (a[k] == B) begin
            if (n[k] < 8) pu[k] = 1; else ovf[k] = 1;
          end else begin
            if (d[k][2]) unf[k] = 0;
            if (d[k][3]) ovf[k] = 0;
          end
        end else if ((a[k] == B || a[k] == S) && l[k]) begin
          if (a[k] == B) begin
            if (n[p] > 0) begin mo[k] = q[p][0]; po[p] = 1; end
            else begin mo[k] = 16'h0; unf[k] = 1; end
          end else
            mo[k] = {8'(n[p]), 4'h0, ovf[k], unf[k], n[k] == 8, n[p] > 0};
        end
      end
      for (int k = 0; k < 2; k++) begin
        if (po[k]) void'(q[k].pop_front());
        if (pu[k]) q[k].push_back(d[k]);
      end
    end
    chk("model_out0", dataOUT0, mo[0]);
    chk("model_out1", dataOUT1, mo[1]);
  endtask

  task automatic c0(input logic [15:0] a, input logic [15:0] d, input logic l, input logic w);
    step(1'b1, a, d, l, w, 16'h0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic c1(input logic [15:0] a, input logic [15:0] d, input logic l, input logic w);
    step(1'b1, 16'h0, 16'h0, 1'b0, 1'b0, a, d, l, w);
  endtask

  function automatic logic [15:0] ra();
    int s;
    s = $urandom_range(0, 9);
    return s < 4 ? B : s < 7 ? S : s == 7 ? M : s == 8 ? B - 16'h1 : 16'($urandom);
  endfunction

  initial begin
    tv[0]  = '{B, 16'h1234, 0, 1, 16'h0, 16'h0, 0, 0, 16'h0000, 16'h0000};
    tv[1]  = '{B, 16'hBEEF, 0, 1, 16'h0, 16'h0, 0, 0, 16'h0000, 16'h0000};
    tv[2]  = '{B, 16'h0001, 0, 1, 16'h0, 16'h0, 0, 0, 16'h0000, 16'h0000};
    tv[3]  = '{16'h0, 16'h0, 0, 0, S, 16'h0, 1, 0, 16'h0000, 16'h0301};
    tv[4]  = '{16'h0, 16'h0, 0, 0, B, 16'h0, 1, 0, 16'h0000, 16'h1234};
    tv[5]  = '{16'h0, 16'h0, 0, 0, B, 16'h0, 1, 0, 16'h0000, 16'hBEEF};
    tv[6]  = '{16'h0, 16'h0, 0, 0, B, 16'h0, 1, 0, 16'h0000, 16'h0001};
    tv[7]  = '{B, 16'h0, 1, 0, 16'h0, 16'h0, 0, 0, 16'h0000, 16'h0001};
    tv[8]  = '{S, 16'h0, 1, 0, 16'h0, 16'h0, 0, 0, 16'h0004, 16'h0001};
    tv[9]  = '{S, 16'h0004, 0, 1, 16'h0, 16'h0, 0, 0, 16'h0004, 16'h0001};
    tv[10] = '{S, 16'h0, 1, 0, 16'h0, 16'h0, 0, 0, 16'h0000, 16'h0001};
    tv[11] = '{B, 16'h00AA, 0, 1, B, 16'h00BB, 1, 1, 16'h0000, 16'h0001};
    tv[12] = '{B, 16'h0, 1, 0, B, 16'h0, 1, 0, 16'h00BB, 16'h00AA};
    tv[13] = '{S, 16'h0, 1, 0, S, 16'h0, 1, 0, 16'h0000, 16'h0000};

    step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    step(1'b0, B, 16'h1, 1'b0, 1'b1, B, 16'h2, 1'b0, 1'b1);
    chk("reset_out0", dataOUT0, 16'h0000);
    c1(S, 16'h0, 1'b1, 1'b0);
    chk("idle_status", dataOUT1, 16'h0000);

    for (int i = 0; i < 14; i++) begin
      step(1'b1, tv[i].a0, tv[i].d0, tv[i].l0, tv[i].w0, tv[i].a1, tv[i].d1, tv[i].l1, tv[i].w1);
      chk($sformatf("vec%0d_out0", i), dataOUT0, tv[i].e0);
      chk($sformatf("vec%0d_out1", i), dataOUT1, tv[i].e1);
    end

    for (int i = 0; i < 9; i++) c0(B, 16'(i), 1'b0, 1'b1);
    c0(S, 16'h0, 1'b1, 1'b0);
    chk("full_ovf_status", dataOUT0, 16'h000A);
    for (int i = 0; i < 8; i++) begin
      c1(B, 16'h0, 1'b1, 1'b0);
      chk($sformatf("drain%0d", i), dataOUT1, 16'(i));
    end
    c1(B, 16'h0, 1'b1, 1'b0);
    chk("word8_absent", dataOUT1, 16'h0000);
    c1(S, 16'h0, 1'b1, 1'b0);
    chk("unf1_status", dataOUT1, 16'h0004);
    c1(S, 16'h0004, 1'b0, 1'b1);
    c0(S, 16'h0008, 1'b0, 1'b1);
    c0(S, 16'h0, 1'b1, 1'b0);
    chk("ovf0_cleared", dataOUT0, 16'h0000);

    for (int i = 0; i < 4; i++) c0(B, 16'(100 + i), 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, B, 16'(200 + i), 1'b0, 1'b1, B, 16'h0, 1'b1, 1'b0);
      chk($sformatf("stream%0d", i), dataOUT1, i < 4 ? 16'(100 + i) : 16'(196 + i));
    end
    c1(S, 16'h0, 1'b1, 1'b0);
    chk("stream_count", dataOUT1, 16'h0401);
    c0(S, 16'h0, 1'b1, 1'b0);
    chk("stream_flags", dataOUT0, 16'h0000);
    for (int i = 0; i < 4; i++) c0(B, 16'(300 + i), 1'b0, 1'b1);
    step(1'b1, B, 16'hDEAD, 1'b0, 1'b1, B, 16'h0, 1'b1, 1'b0);
    chk("full_pop_head", dataOUT1, 16'd216);
    c0(S, 16'h0, 1'b1, 1'b0);
    chk("full_pop_ovf", dataOUT0, 16'h0008);
    c1(S, 16'h0, 1'b1, 1'b0);
    chk("full_pop_count", dataOUT1, 16'h0701);
    c0(S, 16'h0008, 1'b0, 1'b1);

    c1(B, 16'h0, 1'b1, 1'b0);
    c1(B, 16'h0, 1'b1, 1'b0);
    c1(S, 16'h0, 1'b1, 1'b0);
    chk("pre_reset_count", dataOUT1, 16'h0501);
    step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    chk("midrst_out1", dataOUT1, 16'h0000);
    c1(S, 16'h0, 1'b1, 1'b0);
    chk("midrst_count", dataOUT1, 16'h0000);
    c0(M, 16'h5555, 1'b0, 1'b1);
    c0(B, 16'h0077, 1'b0, 1'b1);
    c1(S, 16'h0, 1'b1, 1'b0);
    chk("miss_no_push", dataOUT1, 16'h0101);
    c1(M, 16'h0, 1'b1, 1'b0);
    chk("miss_load_hold", dataOUT1, 16'h0101);

    for (int i = 0; i < 800; i++)
      step($urandom_range(0, 99) != 0,
           ra(), 16'($urandom), $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
           ra(), 16'($urandom), $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/core_mailbox.md
# core_mailbox

Memory-mapped inter-core mailbox that responds to the data-bus accesses of both NRISC cores. It sits beside the shared data memory and gives each core a word-wide FIFO toward the other core, plus a status register. Core 0 writes land in the 0→1 FIFO and core 1 reads drain it; the 1→0 FIFO is symmetric. The block gives the two cores flow-controlled message passing without spin-locks on shared RAM.

## Interface
- TAM, 16, data and address word width
- LDepth, 3, log2 of FIFO depth; each FIFO holds 2^LDepth words; LDepth ≤ 7
- BASE, 16'h0200, mailbox base address; DATA register at BASE, STATUS register at BASE+1
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-low reset
- dataIN0 / dataIN1  in  TAM  write data from core 0 / core 1
- dataADDR0 / dataADDR1  in  TAM  access address from core 0 / core 1
- dataLoad0 / dataLoad1  in  1  read strobe from core 0 / core 1, one cycle per access
- dataWrite0 / dataWrite1  in  1  write strobe from core 0 / core 1, one cycle per access
- dataOUT0 / dataOUT1  out  TAM  registered read data to core 0 / core 1

## Operation
Each core port below is described as core k, with peer p. Core k's TX FIFO is core p's RX FIFO.

- **Hit decode:** an access hits when dataADDRk == BASE or BASE+1. Accesses that miss are ignored completely: no state change, and dataOUTk holds its value.
- **Write to DATA:**
  - If TX is not full: push dataINk.
  - If TX is full: drop the word and set the sticky ovf_k flag.
- **Read of DATA:**
  - If RX is not empty: pop, and dataOUTk gets the head word.
  - If RX is empty: no pop, dataOUTk gets 0, and the sticky unf_k flag is set.
- **Read of STATUS:** dataOUTk gets the following fields:
  - [0] RX not empty
  - [1] TX full
  - [2] unf_k
  - [3] ovf_k
  - [7:4] 0
  - [TAM-1:8] RX count, zero-extended, range 0..2^LDepth
- **Write to STATUS:** write-1-to-clear. dataINk[2] clears unf_k and dataINk[3] clears ovf_k. Other bits are ignored.
- **Load and write on the same cycle from the same core:** the write is performed and the load is ignored; dataOUTk holds.
- **FIFO storage:** each FIFO is a circular buffer.
  - Read and write pointers are LDepth bits and wrap modulo 2^LDepth.
  - The count is LDepth+1 bits.
- **Full/empty tests:** these use the count registered at the start of the cycle.
  - A push into a full FIFO is dropped even if the peer pops it in the same cycle.
  - A pop from an empty FIFO is refused even if the peer pushes it in the same cycle.
  - A push and a pop in the same cycle on a FIFO that is neither full nor empty both take effect, and the count is unchanged.
- **Flag set and clear on the same cycle:** a flag cannot be set and cleared by the same core in the same cycle, because the write-priority rule prevents it.
- **Independence:** the two directions are fully independent, and both cores may access the block every cycle.

## Timing
- **Reset** (rst = 0 sampled at a rising edge):
  - Both FIFOs are emptied: pointers = 0, counts = 0.
  - unf_0, unf_1, ovf_0 and ovf_1 are cleared to 0.
  - dataOUT0 and dataOUT1 are set to 0.
  - FIFO storage contents are not reset.
  - Reset takes priority over any simultaneous access, so a push or pop on the reset cycle is lost.
- **Read latency:** 1 cycle. The load is sampled at edge N, and dataOUTk is valid after edge N and holds until the next hitting load.
- **Write latency:**
  - A word pushed at edge N is poppable by a peer load sampled at edge N+1.
  - The status count and flags reflect the push from edge N onward.
- **STATUS read:** returns the state as it was before any same-edge push or pop by the peer.
- **Throughput:** one push and one pop per FIFO per cycle.

## Test plan
- **Reset and idle:** hold rst = 0 for 2 cycles, release, then core 1 reads STATUS → dataOUT1 = 16'h0000 one cycle after the load.
- **Ordered transfer:** core 0 writes 16'h1234, 16'hBEEF, 16'h0001. Core 1 reads STATUS → 16'h0301 (count 3, not empty). Core 1 then reads DATA three times → 1234, BEEF, 0001 in order.
- **Full/overflow:** core 0 writes 9 words, 0..8, with LDepth = 3.
  - Core 0 STATUS → bit1 = 1, bit3 = 1.
  - Core 1 then drains 8 words: 0..7, and word 8 is absent.
  - Core 0 writes STATUS with 16'h0008 → ovf_0 = 0.
- **Empty/underflow:** core 0 reads DATA with its RX FIFO empty → dataOUT0 = 0 and STATUS bit2 = 1. Core 0 writes STATUS with 16'h0004 → bit2 = 0.
- **Simultaneous push/pop and wrap:**
  - With the 0→1 FIFO holding 4 words, run 20 cycles in which core 0 writes and core 1 reads on every cycle. Require the count to stay at 4, no data to be lost or reordered across pointer wrap, and no flags to be set.
  - Push into a full FIFO while it is popped on the same cycle: the push is dropped and ovf_0 is set.
- **Reset mid-operation and address miss:**
  - Assert rst with 5 words queued → count 0 afterwards.
  - Write to BASE+2 → no push.
  - Load from BASE+2 → dataOUT holds its previous value.
